// File: rtl/touch_scan_ctrl.sv
// Scan controller for an XPT2046-class resistive-touch ADC: debounces pen-down,
// runs 24-clock SPI frames alternating X/Y, averages 2^AVG_LOG2 pairs per report.
module touch_scan_ctrl #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned SETTLE_CYC = 5000,
  parameter int unsigned GAP_CYC    = 50,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pen_irq_n,
  input  logic        spi_miso,
  output logic        spi_mosi,
  output logic        spi_sclk,
  output logic        spi_ss_n,
  output logic [11:0] coord_x,
  output logic [11:0] coord_y,
  output logic        coord_valid,
  input  logic        coord_ready,
  output logic        pen_down
);

  localparam int unsigned AW      = 12 + AVG_LOG2;
  localparam int unsigned NPAIR   = 1 << AVG_LOG2;
  localparam int unsigned PW      = AVG_LOG2 + 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned DW      = $clog2(CLK_DIV);
  localparam logic [7:0]  CMD_X   = 8'hD0;
  localparam logic [7:0]  CMD_Y   = 8'h90;

  typedef enum logic [2:0] {IDLE, SETTLE, FRAME, GAP, OUTPUT} state_t;

  state_t        state;
  logic          pen_meta;
  logic          pen_sync;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div_cnt;
  logic [5:0]    half;
  logic          axis_y;
  logic [11:0]   sample;
  logic [AW-1:0] acc_x;
  logic [AW-1:0] acc_y;
  logic [PW-1:0] pairs;

  logic [5:0]    half_nx;
  logic [4:0]    period;
  logic [7:0]    cmd;
  logic          cmd_bit;
  logic          capture;

  // Half-period index within a frame: even halves have SCLK low, odd halves high.
  always_comb begin
    half_nx = half + 6'd1;
    period  = half_nx[5:1];
    cmd     = axis_y ? CMD_Y : CMD_X;
    cmd_bit = (period < 5'd8) ? cmd[3'd7 - period[2:0]] : 1'b0;
    capture = (period >= 5'd9) && (period <= 5'd20);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_meta <= 1'b1;
      pen_sync <= 1'b1;
    end else begin
      pen_meta <= pen_irq_n;
      pen_sync <= pen_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      div_cnt     <= '0;
      half        <= '0;
      axis_y      <= 1'b0;
      sample      <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      pairs       <= '0;
      spi_mosi    <= 1'b0;
      spi_sclk    <= 1'b0;
      spi_ss_n    <= 1'b1;
      coord_x     <= '0;
      coord_y     <= '0;
      coord_valid <= 1'b0;
      pen_down    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !pen_sync) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end

        SETTLE: begin
          if (pen_sync) begin
            state <= IDLE;
          end else if (cnt == CW'(SETTLE_CYC - 1)) begin
            pen_down <= 1'b1;
            axis_y   <= 1'b0;
            state    <= FRAME;
            spi_ss_n <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= CMD_X[7];
            div_cnt  <= '0;
            half     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FRAME: begin
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (half == 6'd47) begin
              spi_ss_n <= 1'b1;
              spi_sclk <= 1'b0;
              spi_mosi <= 1'b0;
              state    <= GAP;
              cnt      <= '0;
              axis_y   <= ~axis_y;
              if (axis_y) begin
                acc_y <= acc_y + AW'(sample);
                pairs <= pairs + 1'b1;
              end else begin
                acc_x <= acc_x + AW'(sample);
              end
            end else begin
              half <= half_nx;
              if (half_nx[0]) begin
                spi_sclk <= 1'b1;
                if (capture) sample <= {sample[10:0], spi_miso};
              end else begin
                spi_sclk <= 1'b0;
                spi_mosi <= cmd_bit;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt == CW'(GAP_CYC - 1)) begin
            if (pen_sync || !enable) begin
              state    <= IDLE;
              pen_down <= 1'b0;
              acc_x    <= '0;
              acc_y    <= '0;
              pairs    <= '0;
              axis_y   <= 1'b0;
            end else if (pairs == PW'(NPAIR)) begin
              state       <= OUTPUT;
              coord_x     <= acc_x[AVG_LOG2 +: 12];
              coord_y     <= acc_y[AVG_LOG2 +: 12];
              coord_valid <= 1'b1;
              acc_x       <= '0;
              acc_y       <= '0;
              pairs       <= '0;
            end else begin
              state    <= FRAME;
              spi_ss_n <= 1'b0;
              spi_sclk <= 1'b0;
              spi_mosi <= cmd[7];
              div_cnt  <= '0;
              half     <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        OUTPUT: begin
          if (coord_ready) begin
            coord_valid <= 1'b0;
            state       <= GAP;
            cnt         <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Bench for touch_scan_ctrl: ADC reference model feeds samples and queues expected
// averages; an output monitor pops and compares on each handshake.
module tb_touch_scan_ctrl;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned SETTLE_CYC = 40;
  localparam int unsigned GAP_CYC    = 6;
  localparam int unsigned AVG_LOG2   = 2;
  localparam int unsigned NPAIR      = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        pen_irq_n = 1'b1;
  logic        spi_miso = 1'b0;
  logic        coord_ready = 1'b0;
  logic        spi_mosi, spi_sclk, spi_ss_n, coord_valid, pen_down;
  logic [11:0] coord_x, coord_y;

  always #5 clk = ~clk;

  touch_scan_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .SETTLE_CYC(SETTLE_CYC),
    .GAP_CYC   (GAP_CYC),
    .AVG_LOG2  (AVG_LOG2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pen_irq_n  (pen_irq_n),
    .spi_miso   (spi_miso),
    .spi_mosi   (spi_mosi),
    .spi_sclk   (spi_sclk),
    .spi_ss_n   (spi_ss_n),
    .coord_x    (coord_x),
    .coord_y    (coord_y),
    .coord_valid(coord_valid),
    .coord_ready(coord_ready),
    .pen_down   (pen_down)
  );

  int checks = 0;
  int errors = 0;
  int handshakes = 0;
  int frames_total = 0;
  int data_mode = 0;   // 0 random, 1 fixed ABC/123, 2 X from xtab
  int rdy_mode = 0;    // 0 random, 1 always ready, 2 never ready
  logic [23:0] exp_q[$];
  logic [11:0] xs[$];
  logic [11:0] ys[$];
  logic [11:0] xtab[4] = '{12'd100, 12'd101, 12'd102, 12'd104};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       coord_ready = 1'($urandom_range(0, 1));
        1:       coord_ready = 1'b1;
        default: coord_ready = 1'b0;
      endcase
    end
  end

  // ADC model: decodes the command byte, serves a 12-bit sample on rising edges
  // 10..21, and turns each completed set of pairs into one expected coordinate.
  initial begin : adc_model
    logic pss, psc, ppd, is_x;
    int rises, nxt, sx, sy;
    logic [23:0] rx;
    logic [11:0] cur;
    logic [7:0] want_cmd;
    pss = 1'b1; psc = 1'b0; ppd = 1'b0; is_x = 1'b1;
    rises = 0; rx = '0; cur = '0;
    forever begin
      @(spi_ss_n or spi_sclk or pen_down);
      if (pen_down === 1'b1 && ppd !== 1'b1) begin
        xs.delete();
        ys.delete();
      end
      if (pss === 1'b1 && spi_ss_n === 1'b0) begin
        rises = 0;
        rx = '0;
        frames_total++;
      end
      if (psc === 1'b0 && spi_sclk === 1'b1 && spi_ss_n === 1'b0) begin
        rises++;
        rx = {rx[22:0], spi_mosi};
        if (rises == 8) begin
          want_cmd = (xs.size() == ys.size()) ? 8'hD0 : 8'h90;
          check("mosi_cmd", 32'(rx[7:0]), 32'(want_cmd));
          is_x = (rx[6:4] == 3'b101);
          case (data_mode)
            1:       cur = is_x ? 12'hABC : 12'h123;
            2:       cur = is_x ? xtab[xs.size() % 4] : 12'($urandom);
            default: cur = 12'($urandom);
          endcase
        end
      end
      if (psc === 1'b1 && spi_sclk === 1'b0 && spi_ss_n === 1'b0) begin
        nxt = rises + 1;
        if (nxt >= 10 && nxt <= 21) spi_miso = cur[21 - nxt];
        else spi_miso = 1'($urandom);
      end
      if (pss === 1'b0 && spi_ss_n === 1'b1 && reset_n === 1'b1) begin
        check("sclk_rises", 32'(rises), 32'd24);
        check("mosi_tail_zero", 32'(rx[15:0]), 32'd0);
        if (is_x) xs.push_back(cur);
        else ys.push_back(cur);
        if (ys.size() == NPAIR) begin
          sx = 0;
          sy = 0;
          foreach (xs[i]) sx += int'(xs[i]);
          foreach (ys[i]) sy += int'(ys[i]);
          exp_q.push_back({12'(sx >> AVG_LOG2), 12'(sy >> AVG_LOG2)});
          xs.delete();
          ys.delete();
        end
      end
      pss = spi_ss_n;
      psc = spi_sclk;
      ppd = pen_down;
    end
  end

  initial begin : monitor
    logic stall, drop_pend;
    logic [11:0] hx, hy;
    logic [23:0] e;
    stall = 1'b0; drop_pend = 1'b0; hx = '0; hy = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        stall = 1'b0;
        drop_pend = 1'b0;
      end else begin
        if (drop_pend) begin
          check("valid_drop", 32'(coord_valid), 32'd0);
          drop_pend = 1'b0;
        end
        if (stall) begin
          check("hold_valid", 32'(coord_valid), 32'd1);
          check("hold_x", 32'(coord_x), 32'(hx));
          check("hold_y", 32'(coord_y), 32'(hy));
          stall = 1'b0;
        end
        if (coord_valid === 1'b1) begin
          check("ss_high_out", 32'(spi_ss_n), 32'd1);
          if (coord_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_out: got x=%h y=%h want no output", coord_x, coord_y);
            end else begin
              e = exp_q.pop_front();
              if (coord_x !== e[23:12] || coord_y !== e[11:0]) begin
                errors++;
                $display("FAIL coord: got x=%h y=%h want x=%h y=%h", coord_x, coord_y, e[23:12], e[11:0]);
              end
            end
            handshakes++;
            drop_pend = 1'b1;
          end else begin
            stall = 1'b1;
            hx = coord_x;
            hy = coord_y;
          end
        end
      end
    end
  end

  task automatic wait_ss_low(input string name, input int max);
    int n = 0;
    while (spi_ss_n !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(spi_ss_n), 32'd0);
  endtask

  task automatic wait_pen_up(input string name, input int max);
    int n = 0;
    while (pen_down !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(pen_down), 32'd0);
  endtask

  task automatic wait_frame(input string name, input int k, input int max);
    int n = 0;
    while (!(spi_ss_n === 1'b0 && (xs.size() + ys.size() + 1) == k) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(xs.size() + ys.size() + 1), 32'(k));
  endtask

  task automatic wait_handshake(input string name, input int h0, input int max);
    int n = 0;
    while (handshakes == h0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(handshakes), 32'(h0 + 1));
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, h0, f0;

    // Reset held with random inputs
    repeat (10) begin
      @(negedge clk);
      pen_irq_n = 1'($urandom);
      enable    = 1'($urandom);
    end
    check("rst_ss_n", 32'(spi_ss_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_x", 32'(coord_x), 32'd0);
    check("rst_y", 32'(coord_y), 32'd0);
    check("rst_valid", 32'(coord_valid), 32'd0);
    check("rst_pen_down", 32'(pen_down), 32'd0);
    @(negedge clk);
    pen_irq_n = 1'b1;
    enable    = 1'b1;
    reset_n   = 1'b1;
    repeat (5) @(negedge clk);

    // Fixed samples, always ready, latency from pen-down to first valid
    data_mode = 1;
    rdy_mode  = 1;
    h0 = handshakes;
    pen_irq_n = 1'b0;
    n = 0;
    while (coord_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 856 || n > 860) begin
      errors++;
      $display("FAIL latency: got %0d cycles want 856..860", n);
    end
    wait_handshake("fixed_out", h0, 50);
    wait_frame("fixed_next_frame", 1, 300);
    pen_irq_n = 1'b1;
    wait_pen_up("fixed_pen_up", 400);
    repeat (20) @(negedge clk);

    // Averaging over a known X table, two bursts, then a lift during pair 3
    data_mode = 2;
    rdy_mode  = 0;
    h0 = handshakes;
    pen_irq_n = 1'b0;
    wait_handshake("avg_out1", h0, 3000);
    wait_handshake("avg_out2", h0 + 1, 3000);
    wait_frame("avg_pair3", 5, 1000);
    pen_irq_n = 1'b1;
    h0 = handshakes;
    wait_pen_up("lift_pen_up", 400);
    repeat (50) @(negedge clk);
    check("lift_no_out", 32'(handshakes), 32'(h0));
    check("lift_no_pending", 32'(exp_q.size()), 32'd0);

    // Bounce shorter than the settle time
    f0 = frames_total;
    pen_irq_n = 1'b0;
    repeat (10) @(negedge clk);
    pen_irq_n = 1'b1;
    repeat (100) @(negedge clk);
    check("bounce_no_frame", 32'(frames_total), 32'(f0));
    check("bounce_pen_down", 32'(pen_down), 32'd0);

    // Backpressure
    data_mode = 0;
    rdy_mode  = 2;
    repeat (2) @(negedge clk);
    h0 = handshakes;
    pen_irq_n = 1'b0;
    n = 0;
    while (coord_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 32'(coord_valid), 32'd1);
    f0 = frames_total;
    repeat (1000) @(negedge clk);
    check("bp_still_valid", 32'(coord_valid), 32'd1);
    check("bp_no_frames", 32'(frames_total), 32'(f0));
    rdy_mode = 1;
    wait_handshake("bp_out", h0, 50);
    wait_ss_low("bp_resume", 100);
    pen_irq_n = 1'b1;
    wait_pen_up("bp_pen_up", 400);
    repeat (20) @(negedge clk);

    // Enable dropped in the middle of a frame
    h0 = handshakes;
    pen_irq_n = 1'b0;
    wait_frame("en_frame3", 3, 2000);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    f0 = frames_total;
    wait_pen_up("en_pen_up", 400);
    repeat (50) @(negedge clk);
    check("en_no_new_frame", 32'(frames_total), 32'(f0));
    check("en_no_out", 32'(handshakes), 32'(h0));
    check("en_ss_high", 32'(spi_ss_n), 32'd1);
    pen_irq_n = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;

    // Asynchronous reset mid-frame
    pen_irq_n = 1'b0;
    wait_ss_low("rst_frame", 1000);
    repeat (30) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_ss_n", 32'(spi_ss_n), 32'd1);
    check("midrst_sclk", 32'(spi_sclk), 32'd0);
    check("midrst_mosi", 32'(spi_mosi), 32'd0);
    check("midrst_valid", 32'(coord_valid), 32'd0);
    check("midrst_pen_down", 32'(pen_down), 32'd0);
    pen_irq_n = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
